// File: rtl/pipeline_hazard_controller_if.sv
// Hazard-controller bus. The pipeline side (master) drives the operand and handshake
// status; the controller (slave) returns the stall/invalid controls and the event counters.
interface pipeline_hazard_controller_if #(
  parameter int unsigned COUNT_WIDTH = 32
);
  logic [3:0]             rs1_ID;
  logic [3:0]             rs2_ID;
  logic                   rs1_used_ID;
  logic                   rs2_used_ID;
  logic [3:0]             rd_EX;
  logic                   mem_read_EX;
  logic                   regfile_we_EX;
  logic                   branch_taken_EX;
  logic                   dmem_req_MEM;
  logic                   dmem_ready;
  logic                   stall_IF;
  logic                   stall_ID;
  logic                   stall_EX;
  logic                   invalid_IF;
  logic                   invalid_ID;
  logic [COUNT_WIDTH-1:0] stall_count;
  logic [COUNT_WIDTH-1:0] flush_count;

  modport master (
    output rs1_ID, rs2_ID, rs1_used_ID, rs2_used_ID, rd_EX,
    output mem_read_EX, regfile_we_EX, branch_taken_EX,
    output dmem_req_MEM, dmem_ready,
    input  stall_IF, stall_ID, stall_EX, invalid_IF, invalid_ID,
    input  stall_count, flush_count
  );

  modport slave (
    input  rs1_ID, rs2_ID, rs1_used_ID, rs2_used_ID, rd_EX,
    input  mem_read_EX, regfile_we_EX, branch_taken_EX,
    input  dmem_req_MEM, dmem_ready,
    output stall_IF, stall_ID, stall_EX, invalid_IF, invalid_ID,
    output stall_count, flush_count
  );
endinterface

// File: rtl/pipeline_hazard_controller.sv
// Stall/flush sequencer for the 5-stage RV32E pipeline: resolves memory waits, taken-branch
// redirects and load-use hazards combinationally, and counts stall cycles and flushes.
module pipeline_hazard_controller #(
  parameter int unsigned REDIRECT_CYCLES = 1,
  parameter int unsigned COUNT_WIDTH     = 32
) (
  input logic                         clk,
  input logic                         rst_n,
  pipeline_hazard_controller_if.slave hz
);

  typedef enum logic [1:0] {
    RUN,
    MEM_WAIT,
    REDIRECT
  } state_e;

  localparam logic [2:0] REDIR_LOAD = 3'(REDIRECT_CYCLES);

  state_e                 state_q, state_d;
  logic [2:0]             redir_q, redir_d;
  logic [COUNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;
  logic [COUNT_WIDTH-1:0] flush_cnt_q, flush_cnt_d;

  logic mem_stall;
  logic rs1_hit, rs2_hit, load_use;
  logic stall_if, stall_id, stall_ex;
  logic inv_if, inv_id;
  logic flush_inc;

  assign mem_stall = hz.dmem_req_MEM & ~hz.dmem_ready;
  assign rs1_hit   = hz.rs1_used_ID & (hz.rs1_ID == hz.rd_EX);
  assign rs2_hit   = hz.rs2_used_ID & (hz.rs2_ID == hz.rd_EX);
  assign load_use  = hz.mem_read_EX & hz.regfile_we_EX & (hz.rd_EX != 4'd0) & (rs1_hit | rs2_hit);

  // Priority: memory wait freezes everything (a branch in EX stays put until it clears),
  // then a taken branch squashes IF/ID, then load-use inserts one ID/EX bubble.
  always_comb begin
    state_d   = state_q;
    redir_d   = redir_q;
    stall_if  = 1'b0;
    stall_id  = 1'b0;
    stall_ex  = 1'b0;
    inv_if    = 1'b0;
    inv_id    = 1'b0;
    flush_inc = 1'b0;

    if (mem_stall) begin
      stall_if = 1'b1;
      stall_id = 1'b1;
      stall_ex = 1'b1;
      state_d  = MEM_WAIT;
    end else if (hz.branch_taken_EX) begin
      inv_if    = 1'b1;
      inv_id    = 1'b1;
      flush_inc = 1'b1;
      if (REDIRECT_CYCLES > 0) begin
        state_d = REDIRECT;
        redir_d = REDIR_LOAD;
      end else begin
        state_d = RUN;
      end
    end else if (state_q == REDIRECT) begin
      inv_if = 1'b1;
      if (redir_q <= 3'd1) begin
        state_d = RUN;
        redir_d = '0;
      end else begin
        redir_d = redir_q - 3'd1;
      end
    end else begin
      stall_if = load_use;
      stall_id = load_use;
      state_d  = RUN;
    end

    stall_cnt_d = stall_cnt_q + COUNT_WIDTH'(stall_if);
    flush_cnt_d = flush_cnt_q + COUNT_WIDTH'(flush_inc);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RUN;
      redir_q     <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      redir_q     <= redir_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  // During reset the pipeline registers are filled with bubbles.
  assign hz.stall_IF    = rst_n & stall_if;
  assign hz.stall_ID    = rst_n & stall_id;
  assign hz.stall_EX    = rst_n & stall_ex;
  assign hz.invalid_IF  = ~rst_n | inv_if;
  assign hz.invalid_ID  = ~rst_n | inv_id;
  assign hz.stall_count = stall_cnt_q;
  assign hz.flush_count = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Directed-vector scoreboard bench for pipeline_hazard_controller (REDIRECT_CYCLES=2, COUNT_WIDTH=4).
module tb_pipeline_hazard_controller;

  localparam int unsigned CW = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pipeline_hazard_controller_if #(.COUNT_WIDTH(CW)) bus ();

  pipeline_hazard_controller #(
    .REDIRECT_CYCLES(2),
    .COUNT_WIDTH    (CW)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .hz   (bus)
  );

  typedef struct packed {
    logic [3:0] rs1;
    logic [3:0] rs2;
    logic [3:0] rd;
    logic       u1, u2, mr, we, br, req, rdy;
  } pat_t;

  typedef struct {
    logic [4:0]    o;   // {stall_IF, stall_ID, stall_EX, invalid_IF, invalid_ID}
    logic [CW-1:0] sc;
    logic [CW-1:0] fc;
    int            idx;
  } exp_t;

  localparam pat_t P_IDLE  = '{default: '0};
  localparam pat_t P_LU    = '{rs2: 4'd5, rd: 4'd5, u2: 1'b1, mr: 1'b1, we: 1'b1, default: '0};
  localparam pat_t P_LU1   = '{rs1: 4'd7, rd: 4'd7, u1: 1'b1, mr: 1'b1, we: 1'b1, default: '0};
  localparam pat_t P_LU0   = '{rs2: 4'd0, rd: 4'd0, u2: 1'b1, mr: 1'b1, we: 1'b1, default: '0};
  localparam pat_t P_NOWE  = '{rs2: 4'd5, rd: 4'd5, u2: 1'b1, mr: 1'b1, default: '0};
  localparam pat_t P_NOUSE = '{rs2: 4'd5, rd: 4'd5, mr: 1'b1, we: 1'b1, default: '0};
  localparam pat_t P_MW    = '{req: 1'b1, default: '0};
  localparam pat_t P_MR    = '{req: 1'b1, rdy: 1'b1, default: '0};
  localparam pat_t P_BR    = '{br: 1'b1, default: '0};
  localparam pat_t P_BRLU  = '{rs2: 4'd5, rd: 4'd5, u2: 1'b1, mr: 1'b1, we: 1'b1, br: 1'b1, default: '0};
  localparam pat_t P_BRMW  = '{br: 1'b1, req: 1'b1, default: '0};
  localparam pat_t P_BRMR  = '{br: 1'b1, req: 1'b1, rdy: 1'b1, default: '0};

  localparam logic [4:0] E_NONE = 5'b00000;
  localparam logic [4:0] E_RST  = 5'b00011;
  localparam logic [4:0] E_LU   = 5'b11000;
  localparam logic [4:0] E_MW   = 5'b11100;
  localparam logic [4:0] E_BR   = 5'b00011;
  localparam logic [4:0] E_RD   = 5'b00010;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   vec_n  = 0;

  task automatic cyc(input logic r, input pat_t p, input logic [4:0] eo, input int sc, input int fc);
    exp_t e;
    @(posedge clk);
    #1;
    rst_n               = r;
    bus.rs1_ID          = p.rs1;
    bus.rs2_ID          = p.rs2;
    bus.rd_EX           = p.rd;
    bus.rs1_used_ID     = p.u1;
    bus.rs2_used_ID     = p.u2;
    bus.mem_read_EX     = p.mr;
    bus.regfile_we_EX   = p.we;
    bus.branch_taken_EX = p.br;
    bus.dmem_req_MEM    = p.req;
    bus.dmem_ready      = p.rdy;
    e.o   = eo;
    e.sc  = CW'(sc);
    e.fc  = CW'(fc);
    e.idx = vec_n;
    exp_q.push_back(e);
    vec_n++;
  endtask

  // Monitor: outputs are combinational, counters registered; sample mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      logic [4:0] got;
      e   = exp_q.pop_front();
      got = {bus.stall_IF, bus.stall_ID, bus.stall_EX, bus.invalid_IF, bus.invalid_ID};
      checks++;
      if (got !== e.o) begin
        errors++;
        $display("FAIL vec%0d outputs: got %b expected %b", e.idx, got, e.o);
      end
      checks++;
      if (bus.stall_count !== e.sc || bus.flush_count !== e.fc) begin
        errors++;
        $display("FAIL vec%0d counters: got stall=%0d flush=%0d expected stall=%0d flush=%0d",
                 e.idx, bus.stall_count, bus.flush_count, e.sc, e.fc);
      end
    end
  end

  initial begin
    bus.rs1_ID = '0; bus.rs2_ID = '0; bus.rd_EX = '0;
    bus.rs1_used_ID = 1'b0; bus.rs2_used_ID = 1'b0;
    bus.mem_read_EX = 1'b0; bus.regfile_we_EX = 1'b0; bus.branch_taken_EX = 1'b0;
    bus.dmem_req_MEM = 1'b0; bus.dmem_ready = 1'b0;

    // reset forces bubbles regardless of inputs
    cyc(0, P_IDLE, E_RST, 0, 0);
    cyc(0, P_MW,   E_RST, 0, 0);
    cyc(0, P_BR,   E_RST, 0, 0);
    cyc(1, P_IDLE, E_NONE, 0, 0);
    // load-use
    cyc(1, P_LU,    E_LU,   0, 0);
    cyc(1, P_IDLE,  E_NONE, 1, 0);
    cyc(1, P_LU1,   E_LU,   1, 0);
    cyc(1, P_IDLE,  E_NONE, 2, 0);
    cyc(1, P_LU0,   E_NONE, 2, 0);
    cyc(1, P_NOWE,  E_NONE, 2, 0);
    cyc(1, P_NOUSE, E_NONE, 2, 0);
    // memory wait, 4 cycles
    for (int i = 0; i < 4; i++) cyc(1, P_MW, E_MW, 2 + i, 0);
    cyc(1, P_MR,   E_NONE, 6, 0);
    cyc(1, P_IDLE, E_NONE, 6, 0);
    // branch + two redirect cycles
    cyc(1, P_BR,   E_BR,   6, 0);
    cyc(1, P_IDLE, E_RD,   6, 1);
    cyc(1, P_IDLE, E_RD,   6, 1);
    cyc(1, P_IDLE, E_NONE, 6, 1);
    // branch with load-use: flush only
    cyc(1, P_BRLU, E_BR,   6, 1);
    cyc(1, P_IDLE, E_RD,   6, 2);
    cyc(1, P_IDLE, E_RD,   6, 2);
    cyc(1, P_IDLE, E_NONE, 6, 2);
    // branch during redirect restarts it
    cyc(1, P_BR,   E_BR,   6, 2);
    cyc(1, P_IDLE, E_RD,   6, 3);
    cyc(1, P_BR,   E_BR,   6, 3);
    cyc(1, P_IDLE, E_RD,   6, 4);
    cyc(1, P_IDLE, E_RD,   6, 4);
    cyc(1, P_IDLE, E_NONE, 6, 4);
    // branch held behind memory wait
    cyc(1, P_BRMW, E_MW,   6, 4);
    cyc(1, P_BRMW, E_MW,   7, 4);
    cyc(1, P_BRMR, E_BR,   8, 4);
    cyc(1, P_IDLE, E_RD,   8, 5);
    cyc(1, P_IDLE, E_RD,   8, 5);
    cyc(1, P_IDLE, E_NONE, 8, 5);
    // reset in the middle of a redirect
    cyc(1, P_BR,   E_BR,   8, 5);
    cyc(1, P_IDLE, E_RD,   8, 6);
    cyc(0, P_IDLE, E_RST,  0, 0);
    cyc(1, P_IDLE, E_NONE, 0, 0);
    // stall counter wraps at 16
    for (int i = 0; i < 17; i++) cyc(1, P_MW, E_MW, i % 16, 0);
    cyc(1, P_MR,   E_NONE, 1, 0);
    cyc(1, P_IDLE, E_NONE, 1, 0);

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    #2;
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d expected responses left unchecked, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
